// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding, the default address width and the checksum helper.
package imem_loader_pkg;

    localparam int ADDR_W_DEFAULT = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LAST = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Running program checksum: XOR of every word written.
    function automatic logic [31:0] fold_checksum(input logic [31:0] acc, input logic [31:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a program from a valid/ready source into instruction memory while holding the CPU.
// Releases the CPU once every requested word has been written; flags illegal load sizes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_r;
    logic [ADDR_W-1:0] index_r;
    logic [ADDR_W-1:0] last_idx_r;
    logic              wc_legal_s;
    logic [ADDR_W-1:0] last_idx_s;
    logic              xfer_s;

    // A load must cover at least one word and no more than the whole memory.
    always_comb begin
        wc_legal_s = 1'b0;
        if ((word_count != {(ADDR_W+1){1'b0}}) && (word_count <= WC_MAX)) begin
            wc_legal_s = 1'b1;
        end else begin
            wc_legal_s = 1'b0;
        end
    end

    // Modular subtraction: a full-depth count (low bits zero) maps to the top address.
    assign last_idx_s = word_count[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};
    assign xfer_s     = s_valid && s_ready;

    // Loader FSM with index counter, memory write register and checksum.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r    <= ST_IDLE;
            index_r    <= {ADDR_W{1'b0}};
            last_idx_r <= {ADDR_W{1'b0}};
            checksum   <= 32'h0000_0000;
            im_we      <= 1'b0;
            im_addr    <= {ADDR_W{1'b0}};
            im_wdata   <= 32'h0000_0000;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            im_we <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        if (wc_legal_s) begin
                            state_r    <= ST_LOAD;
                            index_r    <= {ADDR_W{1'b0}};
                            last_idx_r <= last_idx_s;
                            checksum   <= 32'h0000_0000;
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            s_ready    <= 1'b1;
                        end else begin
                            state_r <= ST_ERR;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            s_ready <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        im_we    <= 1'b1;
                        im_addr  <= index_r;
                        im_wdata <= s_data;
                        checksum <= fold_checksum(checksum, s_data);
                        index_r  <= index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (index_r == last_idx_r) begin
                            state_r <= ST_LAST;
                            s_ready <= 1'b0;
                        end
                    end
                end
                ST_LAST: begin
                    state_r  <= ST_DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    s_ready  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes queued at drive time, popped on im_we.
module tb_imem_loader;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [10:0] word_count;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    int total_checks = 0;
    int pass_checks  = 0;
    int fail_checks  = 0;
    int writes_seen  = 0;

    wr_t         exp_q[$];
    logic [31:0] words[$];

    imem_loader #(.ADDR_W(10)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) pass_checks++;
        else begin
            fail_checks++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (im_we === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(im_we), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(im_addr), 32'(e.addr));
                chk("write_data", im_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start(input logic [10:0] wc);
        start      = 1'b1;
        word_count = wc;
        step();
        start      = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_im_we"},    32'(im_we),    32'd0);
        chk({tag, "_im_addr"},  32'(im_addr),  32'd0);
        chk({tag, "_im_wdata"}, im_wdata,      32'd0);
        chk({tag, "_s_ready"},  32'(s_ready),  32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_checksum"}, checksum,      32'd0);
    endtask

    // Load the contents of words[]; gap idle cycles between words, optional ignored start pulse.
    task automatic load_words(input string tag, input int gap, input bit poke);
        logic [31:0] ck;
        int n;
        ck = 32'h0000_0000;
        n  = words.size();
        writes_seen = 0;
        do_start(11'(n));
        chk({tag, "_hold_in_load"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_busy_in_load"}, 32'(busy),     32'd1);
        chk({tag, "_done_cleared"}, 32'(done),     32'd0);
        chk({tag, "_err_cleared"},  32'(err),      32'd0);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
            exp_q.push_back('{addr: 10'(i), data: words[i]});
            s_valid = 1'b1;
            s_data  = words[i];
            ck      = ck ^ words[i];
            step();
            s_valid = 1'b0;
            s_data  = $urandom;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                end
                if (poke && i == 0) begin
                    start      = 1'b1;
                    word_count = 11'd1;
                    step();
                    start      = 1'b0;
                end
            end
        end
        chk({tag, "_s_ready_last"}, 32'(s_ready), 32'd0);
        chk({tag, "_busy_last"},    32'(busy),    32'd1);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        chk({tag, "_done"},      32'(done),     32'd1);
        chk({tag, "_cpu_hold"},  32'(cpu_hold), 32'd0);
        chk({tag, "_busy_done"}, 32'(busy),     32'd0);
        chk({tag, "_err_done"},  32'(err),      32'd0);
        chk({tag, "_checksum"},  checksum,      ck);
        step();
        chk({tag, "_write_count"}, 32'(writes_seen), 32'(n));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_err(input string tag, input logic [10:0] wc);
        writes_seen = 0;
        do_start(wc);
        s_valid = 1'b1;
        s_data  = $urandom;
        chk({tag, "_err"},      32'(err),      32'd1);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_s_ready"},  32'(s_ready),  32'd0);
        step();
        step();
        s_valid = 1'b0;
        chk({tag, "_err_held"},   32'(err),         32'd1);
        chk({tag, "_no_writes"},  32'(writes_seen), 32'd0);
    endtask

    initial begin
        Reset      = 1'b0;
        start      = 1'b0;
        word_count = 11'd0;
        s_valid    = 1'b0;
        s_data     = 32'h0000_0000;

        #15;
        check_reset_vals("reset");
        #15;
        Reset = 1'b1;

        words = '{32'h3c10ffff, 32'h36100001, 32'h00000000};
        load_words("basic", 0, 1'b0);
        chk("basic_checksum_const", checksum, 32'h0a00fffe);

        load_words("gap", 2, 1'b0);

        check_err("err_zero", 11'd0);
        check_err("err_1025", 11'd1025);

        words.delete();
        for (int i = 0; i < 1024; i++) words.push_back($urandom);
        load_words("full", 0, 1'b0);

        // Reset in the cycle the second of four writes is on the bus.
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        writes_seen = 0;
        do_start(11'd4);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{addr: 10'(i), data: words[i]});
            s_valid = 1'b1;
            s_data  = words[i];
            step();
        end
        s_data = words[2];
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        step();
        step();
        s_valid = 1'b0;
        Reset   = 1'b1;
        chk("rst_mid_write_count", 32'(writes_seen), 32'd2);
        chk("rst_mid_queue_empty", 32'(exp_q.size()), 32'd0);

        words = '{32'hdeadbeef, 32'h0badf00d};
        load_words("poke", 0, 1'b1);

        words = '{32'hffffffff};
        load_words("reload", 0, 1'b0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
